// File: rtl/famicom_kbd_scanner_if.sv
// Key event stream from the Famicom keyboard scanner to its consumer.
interface famicom_kbd_scanner_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [6:0] evt_code;
  logic       evt_pressed;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_pressed,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_pressed,
    output evt_ready
  );
endinterface

// File: rtl/famicom_kbd_scanner.sv
// Famicom keyboard matrix scanner: drives $4016 phases, samples $4017 nibbles
// into a shadow map, then walks the map emitting one event per changed key.
module famicom_kbd_scanner #(
  parameter int unsigned SETTLE   = 4,
  parameter int unsigned SCAN_GAP = 4096
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  output logic [2:0]                   out_4016,
  input  logic [3:0]                   in_4017,
  output logic [71:0]                  matrix,
  output logic                         scan_done,
  famicom_kbd_scanner_if.master        evt
);

  localparam int unsigned KEYS = 72;
  localparam int unsigned CW   = $clog2(SETTLE + 1);
  localparam int unsigned GW   = $clog2(SCAN_GAP + 1);
  localparam logic [3:0]  LAST_ROW = 4'd8;
  localparam logic [6:0]  LAST_IDX = 7'(KEYS - 1);

  typedef enum logic [2:0] {
    IDLE,
    RST,
    COL0,
    COL1,
    EMIT,
    GAP
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    row, row_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [6:0]    idx, idx_nxt;
  logic [GW-1:0] gap, gap_nxt;
  logic [71:0]   shadow, shadow_nxt;
  logic [71:0]   matrix_nxt;
  logic [2:0]    out_nxt;
  logic          done_nxt;
  logic          valid_nxt;
  logic [6:0]    code_nxt;
  logic          pressed_nxt;
  logic          last;
  logic [6:0]    base;

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      row             <= '0;
      cnt             <= '0;
      idx             <= '0;
      gap             <= '0;
      shadow          <= '0;
      matrix          <= '0;
      out_4016        <= 3'b000;
      scan_done       <= 1'b0;
      evt.evt_valid   <= 1'b0;
      evt.evt_code    <= '0;
      evt.evt_pressed <= 1'b0;
    end else begin
      state           <= state_nxt;
      row             <= row_nxt;
      cnt             <= cnt_nxt;
      idx             <= idx_nxt;
      gap             <= gap_nxt;
      shadow          <= shadow_nxt;
      matrix          <= matrix_nxt;
      out_4016        <= out_nxt;
      scan_done       <= done_nxt;
      evt.evt_valid   <= valid_nxt;
      evt.evt_code    <= code_nxt;
      evt.evt_pressed <= pressed_nxt;
    end
  end

  // Next-state logic; outputs are computed from the next state so they line up with it.
  always_comb begin
    state_nxt   = state;
    row_nxt     = row;
    cnt_nxt     = cnt;
    idx_nxt     = idx;
    gap_nxt     = gap;
    shadow_nxt  = shadow;
    matrix_nxt  = matrix;
    out_nxt     = 3'b000;
    done_nxt    = 1'b0;
    valid_nxt   = 1'b0;
    code_nxt    = evt.evt_code;
    pressed_nxt = evt.evt_pressed;
    last        = (cnt == CW'(SETTLE - 1));
    base        = {row, 3'b000};

    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = RST;
          cnt_nxt   = '0;
        end
      end
      RST: begin
        if (last) begin
          state_nxt = COL0;
          cnt_nxt   = '0;
          row_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      COL0: begin
        if (last) begin
          shadow_nxt[base + 7'd4 +: 4] = ~in_4017;
          state_nxt = COL1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      COL1: begin
        if (last) begin
          shadow_nxt[base +: 4] = ~in_4017;
          cnt_nxt = '0;
          if (row == LAST_ROW) begin
            state_nxt = EMIT;
            idx_nxt   = '0;
          end else begin
            row_nxt   = row + 4'd1;
            state_nxt = COL0;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      EMIT: begin
        // A pending event holds idx until accepted; unchanged keys cost one cycle each.
        if (!evt.evt_valid || evt.evt_ready) begin
          if (evt.evt_valid) begin
            matrix_nxt[idx] = shadow[idx];
          end
          if (idx == LAST_IDX) begin
            state_nxt = GAP;
            idx_nxt   = '0;
            gap_nxt   = '0;
          end else begin
            idx_nxt = idx + 7'd1;
          end
        end
      end
      GAP: begin
        if (gap == GW'(SCAN_GAP - 1)) begin
          state_nxt = IDLE;
          gap_nxt   = '0;
        end else begin
          gap_nxt = gap + GW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    case (state_nxt)
      RST:     out_nxt = 3'b101;
      COL0:    out_nxt = 3'b100;
      COL1:    out_nxt = 3'b110;
      default: out_nxt = 3'b000;
    endcase

    done_nxt = (state_nxt == COL1) && (row_nxt == LAST_ROW) && (cnt_nxt == CW'(SETTLE - 1));

    valid_nxt = (state_nxt == EMIT) && (shadow_nxt[idx_nxt] != matrix_nxt[idx_nxt]);
    if (valid_nxt) begin
      code_nxt    = idx_nxt;
      pressed_nxt = shadow_nxt[idx_nxt];
    end
  end

endmodule

// File: tb/tb_famicom_kbd_scanner.sv
// Directed bench: keyboard responder model plus an event scoreboard.
module tb_famicom_kbd_scanner;

  localparam int unsigned SETTLE   = 4;
  localparam int unsigned SCAN_GAP = 16;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [2:0]  out_4016;
  logic [3:0]  in_4017;
  logic [71:0] matrix;
  logic        scan_done;

  famicom_kbd_scanner_if evt_if ();

  famicom_kbd_scanner #(
    .SETTLE   (SETTLE),
    .SCAN_GAP (SCAN_GAP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .out_4016  (out_4016),
    .in_4017   (in_4017),
    .matrix    (matrix),
    .scan_done (scan_done),
    .evt       (evt_if)
  );

  int errors = 0;
  int checks = 0;

  logic [71:0] keys;
  logic [71:0] model;
  logic [71:0] prev_m;
  logic [71:0] nk;
  logic [7:0]  exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: row reset on bit0, row advance on bit1 falling edge, registered active-low data.
  logic [3:0] rrow = 4'd0;
  logic       prev_b1 = 1'b0;
  logic [6:0] kb;
  assign kb = {rrow, 3'b000};
  always @(posedge clk) begin
    prev_b1 <= out_4016[1];
    if (out_4016[0]) rrow <= 4'd0;
    else if (prev_b1 && !out_4016[1] && rrow < 4'd15) rrow <= rrow + 4'd1;
    if (!out_4016[2]) in_4017 <= 4'h0;
    else if (rrow > 4'd8) in_4017 <= 4'hF;
    else if (!out_4016[1]) in_4017 <= ~keys[kb + 7'd4 +: 4];
    else in_4017 <= ~keys[kb +: 4];
  end

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every accepted event must be the next one the scoreboard expects.
  logic [7:0] e;
  always @(negedge clk) begin
    if (reset === 1'b0 && evt_if.evt_valid === 1'b1 && evt_if.evt_ready === 1'b1) begin
      check("evt_expected", 72'(exp_q.size() != 0), 72'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("evt_code", 72'(evt_if.evt_code), 72'(e[6:0]));
        check("evt_pressed", 72'(evt_if.evt_pressed), 72'(e[7]));
      end
    end
  end

  task automatic set_keys(input logic [71:0] k);
    for (int i = 0; i < 72; i++) begin
      if (k[i] !== model[i]) exp_q.push_back({k[i], 7'(i)});
    end
    model = k;
    keys  = k;
  endtask

  task automatic wait_rst(input int limit, output int n);
    n = 0;
    while (out_4016 !== 3'b101 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("rst_seen", 72'(out_4016 === 3'b101), 72'd1);
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (scan_done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("scan_done_seen", 72'(scan_done === 1'b1), 72'd1);
  endtask

  task automatic run_scan();
    int n;
    @(posedge clk); #1 enable = 1'b1;
    wait_rst(400, n);
    @(posedge clk); #1 enable = 1'b0;
    wait_done(400, n);
    repeat (72 + SCAN_GAP + 4) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cyc, seq_bad, done_at, done_cnt, bad_v, bad_m, bad_o, rst_again;
    logic [2:0] exp3;

    reset = 1'b1;
    enable = 1'b0;
    evt_if.evt_ready = 1'b1;
    keys  = '0;
    model = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset values and quiet idle
    @(negedge clk);
    check("rst_out_4016", 72'(out_4016), 72'd0);
    check("rst_matrix", matrix, 72'd0);
    check("rst_evt_valid", 72'(evt_if.evt_valid), 72'd0);
    check("rst_evt_code", 72'(evt_if.evt_code), 72'd0);
    check("rst_evt_pressed", 72'(evt_if.evt_pressed), 72'd0);
    check("rst_scan_done", 72'(scan_done), 72'd0);
    bad_o = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_4016 !== 3'b000) bad_o++;
    end
    check("idle_quiet", 72'(bad_o), 72'd0);

    // No keys: phase sequence, scan_done position, scan period
    @(posedge clk); #1 enable = 1'b1;
    wait_rst(50, n);
    seq_bad = 0; done_at = 0; done_cnt = 0;
    for (int i = 1; i <= 77; i++) begin
      if (i > 1) @(negedge clk);
      if (i <= 4) exp3 = 3'b101;
      else if (i <= 76) exp3 = (((i - 5) % 8) < 4) ? 3'b100 : 3'b110;
      else exp3 = 3'b000;
      if (out_4016 !== exp3) seq_bad++;
      if (scan_done === 1'b1) begin
        done_cnt++;
        done_at = i;
      end
    end
    check("seq_no_keys", 72'(seq_bad), 72'd0);
    check("scan_done_cycle", 72'(done_at), 72'd76);
    check("scan_done_width", 72'(done_cnt), 72'd1);
    cyc = 77;
    while (out_4016 !== 3'b101 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check("scan_period", 72'(cyc), 72'd166);
    @(posedge clk); #1 enable = 1'b0;
    wait_done(400, n);
    repeat (100) @(negedge clk);
    check("no_keys_matrix", matrix, 72'd0);

    // Single press then release of key 55
    nk = '0; nk[55] = 1'b1;
    set_keys(nk);
    run_scan();
    check("press55_matrix", matrix, model);
    check("press55_drained", 72'(exp_q.size()), 72'd0);
    nk[55] = 1'b0;
    set_keys(nk);
    run_scan();
    check("release55_matrix", matrix, model);
    check("release55_drained", 72'(exp_q.size()), 72'd0);

    // Two keys in one scan; EMIT takes 72 cycles with ready high
    nk = '0; nk[0] = 1'b1; nk[71] = 1'b1;
    set_keys(nk);
    @(posedge clk); #1 enable = 1'b1;
    wait_rst(400, n);
    wait_done(400, n);
    cyc = 0;
    while (out_4016 !== 3'b101 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check("done_to_next_rst", 72'(cyc), 72'd90);
    check("two_keys_matrix", matrix, model);
    check("two_keys_drained", 72'(exp_q.size()), 72'd0);
    @(posedge clk); #1 enable = 1'b0;
    wait_done(400, n);
    repeat (100) @(negedge clk);

    // Backpressure on key 10 with enable held high
    prev_m = model;
    nk = model; nk[10] = 1'b1;
    set_keys(nk);
    @(posedge clk); #1 begin evt_if.evt_ready = 1'b0; enable = 1'b1; end
    wait_rst(400, n);
    wait_done(400, n);
    repeat (15) @(negedge clk);
    check("bp_valid", 72'(evt_if.evt_valid), 72'd1);
    check("bp_code", 72'(evt_if.evt_code), 72'd10);
    check("bp_pressed", 72'(evt_if.evt_pressed), 72'd1);
    bad_v = 0; bad_m = 0; bad_o = 0;
    repeat (100) begin
      @(negedge clk);
      if (evt_if.evt_valid !== 1'b1 || evt_if.evt_code !== 7'd10 || evt_if.evt_pressed !== 1'b1) bad_v++;
      if (matrix !== prev_m) bad_m++;
      if (out_4016 !== 3'b000) bad_o++;
    end
    check("bp_evt_stable", 72'(bad_v), 72'd0);
    check("bp_matrix_stable", 72'(bad_m), 72'd0);
    check("bp_bus_quiet", 72'(bad_o), 72'd0);
    @(posedge clk); #1 evt_if.evt_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_at_release", 72'(evt_if.evt_valid), 72'd1);
    @(negedge clk);
    check("bp_accept_1cycle", 72'(evt_if.evt_valid), 72'd0);
    check("bp_matrix_after", matrix, model);
    wait_rst(400, n);
    @(posedge clk); #1 enable = 1'b0;
    wait_done(400, n);
    repeat (100) @(negedge clk);
    check("bp_drained", 72'(exp_q.size()), 72'd0);

    // Reset during COL1 of row 4 with keys held
    nk = model; nk[3] = 1'b1; nk[37] = 1'b1;
    keys = nk;
    @(posedge clk); #1 enable = 1'b1;
    wait_rst(400, n);
    @(posedge clk); #1 enable = 1'b0;
    repeat (41) @(negedge clk);
    check("pre_reset_phase", 72'(out_4016), 72'(3'b110));
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_out_4016", 72'(out_4016), 72'd0);
    check("reset_matrix", matrix, 72'd0);
    check("reset_evt_valid", 72'(evt_if.evt_valid), 72'd0);
    @(posedge clk); #1 reset = 1'b0;
    model = '0;
    set_keys(nk);
    run_scan();
    check("post_reset_matrix", matrix, model);
    check("post_reset_drained", 72'(exp_q.size()), 72'd0);

    // Enable dropped during row 3: scan and EMIT complete, then stay idle
    nk = model; nk[71] = 1'b0; nk[50] = 1'b1;
    set_keys(nk);
    @(posedge clk); #1 enable = 1'b1;
    wait_rst(400, n);
    repeat (28) @(posedge clk);
    #1 enable = 1'b0;
    wait_done(400, n);
    rst_again = 0;
    repeat (300) begin
      @(negedge clk);
      if (out_4016 !== 3'b000) rst_again++;
    end
    check("en_drop_no_rescan", 72'(rst_again), 72'd0);
    check("en_drop_matrix", matrix, model);
    check("en_drop_drained", 72'(exp_q.size()), 72'd0);
    check("en_drop_valid", 72'(evt_if.evt_valid), 72'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/famicom_kbd_scanner.md
# famicom_kbd_scanner

Host-side scanner for the Famicom keyboard matrix protocol. It drives the three expansion-port output bits ($4016 writes) and samples the four $4017 data bits, mirroring how Family BASIC software reads the keyboard. It walks all 9 rows × 2 columns, keeps a 72-bit debounced-by-scan key map, and emits one press/release event per changed key through a valid/ready stream. It is used for the on-screen keyboard test and OSD hotkeys, and to read a keyboard attached through the expansion port.

## Interface
- SETTLE, default 4, is the number of cycles each drive phase is held before sampling. Legal values are 2 or more, because the responder registers both its row and its data.
- SCAN_GAP, default 4096, is the number of idle cycles between the end of one event walk and the start of the next scan.

Ports:
- clk, in, 1: clock.
- reset, in, 1: reset, synchronous, active-high.
- enable, in, 1: permits new scans. It is sampled only in IDLE.
- out_4016, out, 3: bit0 is the row reset, bit1 is the column select, bit2 is the keyboard enable.
- in_4017, in, 4: matrix data, active-low (0 means pressed). It is synchronous to clk.
- matrix, out, 72: current key state. Index = row*8 + b, and 1 means pressed.
- evt_valid, out, 1: an event is available.
- evt_ready, in, 1: the consumer accepts the event.
- evt_code, out, 7: key index, 0..71.
- evt_pressed, out, 1: 1 for a press, 0 for a release.
- scan_done, out, 1: one-cycle pulse when the last nibble of a scan has been sampled.

## Operation
- The FSM has the states IDLE, RST, COL0, COL1, EMIT and GAP.
- **IDLE:** out_4016=000. If enable=1, go to RST.
- **RST:** out_4016=101 for SETTLE cycles. No sample is taken. Then go to COL0 with row=0.
- **COL0:** out_4016=100 for SETTLE cycles.
  - On the last cycle, capture shadow[row*8+7 : row*8+4] = ~in_4017[3:0].
  - Then go to COL1.
- **COL1:** out_4016=110 for SETTLE cycles.
  - On the last cycle, capture shadow[row*8+3 : row*8+0] = ~in_4017[3:0].
  - If row<8: row += 1 and go to COL0. The 110→100 transition is the falling edge of bit1 that advances the responder's row.
  - If row==8: pulse scan_done and go to EMIT.
- **EMIT:** out_4016=000. An index idx walks 0..71 in ascending order.
  - If shadow[idx]==matrix[idx], idx advances 1 per cycle.
  - Otherwise: evt_valid=1, evt_code=idx, evt_pressed=shadow[idx].
    - Hold these until evt_valid && evt_ready.
    - On acceptance, set matrix[idx] = shadow[idx], deassert evt_valid, and advance idx.
  - After idx 71 is handled, go to GAP.
- **GAP:** a counter runs SCAN_GAP cycles with out_4016=000, then the FSM goes to IDLE.
- matrix changes only on event acceptance, so matrix always equals the integral of the accepted events.
- Deasserting enable mid-scan does not abort. The current scan, EMIT and GAP complete, then the FSM stays in IDLE.
- The shadow register is overwritten each scan. Shadow bits that a scan did not touch cannot exist, because every scan covers all 72 bits.

## Timing
- Reset values: out_4016=000, matrix=0, shadow=0, evt_valid=0, evt_code=0, evt_pressed=0, scan_done=0, state IDLE, row=0, idx=0, gap counter=0.
- **Reset mid-operation:** the abort is immediate.
  - out_4016=000 on the cycle after reset is sampled.
  - No event is emitted and no partial shadow is committed.
- **Scan latency:** from the IDLE→RST transition to scan_done is 19*SETTLE cycles. scan_done is asserted in the cycle of the final COL1 sample.
- **Sampling rule:** the data captured is the in_4017 value present at the clock edge ending the phase's SETTLE-th cycle. Phase outputs are registered and change on the first cycle of the new state.
- **EMIT duration:** 72 cycles plus the handshake stall cycles. A change accepted the same cycle it is presented costs 1 cycle.
- **Backpressure:** with evt_ready low, evt_valid/evt_code/evt_pressed stay stable, idx does not advance, and GAP does not start.
- **Scan period:** with no pending events, scan to scan is 19*SETTLE + 72 + SCAN_GAP + 1 cycles, the extra cycle being IDLE.
- If enable=0 while in IDLE, no bus activity occurs and out_4016 is held at 000.

## Test plan
The bench models a responder with the following behaviour:
- Row reset on bit0=1.
- Row advance on a bit1 falling edge.
- Registered, active-low data: column 0 returns bits 7:4 and column 1 returns bits 3:0.
- Data reads 0000 when bit2=0.

Scenarios:
- **No keys:** reset, then enable=1 and no keys → out_4016 sequence is 101×4, then (100×4, 110×4)×9, then 000. scan_done fires at cycle 76 after leaving IDLE. No evt_valid, and matrix=0.
- **Single press and release:** press row 6 bit 7 ('A') → one event with code=55 and pressed=1, and matrix[55]=1. Release it before the next scan → code=55 and pressed=0.
- **Two keys in one scan:** press row 0 bit 0 and row 8 bit 7 together → two events in order: code 0, then code 71, both pressed=1. EMIT lasts exactly 72 cycles with evt_ready tied high.
- **Backpressure:** hold evt_ready=0 for 100 cycles with an event pending → evt_valid, code and pressed are stable throughout, matrix is unchanged, and out_4016 stays 000 with no new RST. On release, the event is accepted in 1 cycle.
- **Reset mid-scan:** assert reset during COL1 of row 4 with keys pressed → out_4016=000 on the next cycle, matrix=0, no event. The next enabled scan reports all held keys as presses.
- **Enable dropped mid-scan:** deassert enable during row 3 → the scan and EMIT complete, events are delivered, and then the FSM stays in IDLE with no further RST.
